// File: rtl/uart_rx.sv
// UART receiver: start + 8 data (LSB first) + parity + 1/2 stop bits, valid/ack output holding register.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx #(
    parameter int BAUD_DIVISOR = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       two_stop,
    input  logic       odd_parity,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

`ifdef UART_RX_MAJORITY_EN
    // Decision moves one cycle later; reloading with 1 keeps the bit period unchanged.
    localparam logic [13:0] START_DEC = 14'(BAUD_DIVISOR / 2);
    localparam logic [13:0] BIT_DEC   = 14'(BAUD_DIVISOR);
    localparam logic [13:0] RELOAD    = 14'd1;
`else
    localparam logic [13:0] START_DEC = 14'(BAUD_DIVISOR / 2 - 1);
    localparam logic [13:0] BIT_DEC   = 14'(BAUD_DIVISOR - 1);
    localparam logic [13:0] RELOAD    = 14'd0;
`endif

    logic        rx_meta_reg;
    logic        rx_s_reg;
    logic        rx_prev_reg;
    logic [2:0]  state_reg;
    logic [13:0] baud_count_reg;
    logic [2:0]  bit_count_reg;
    logic [7:0]  shift_reg;
    logic        two_stop_reg;
    logic        odd_parity_reg;
    logic        parity_bad_reg;
    logic        stop1_bad_reg;
    logic        frame_bad_reg;
    logic        done_reg;
    logic [7:0]  rx_data_reg;
    logic        rx_valid_reg;
    logic        parity_err_reg;
    logic        frame_err_reg;
    logic        overrun_reg;

    logic [13:0] dec_point;
    logic        decide;
    logic        sample_bit;

    assign dec_point = (state_reg == S_START) ? START_DEC : BIT_DEC;
    assign decide    = (state_reg != S_IDLE) && (baud_count_reg == dec_point);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            early_reg <= 2'b11;
        end else begin
            if (baud_count_reg == dec_point - 14'd2) early_reg[0] <= rx_s_reg;
            if (baud_count_reg == dec_point - 14'd1) early_reg[1] <= rx_s_reg;
        end
    end

    assign sample_bit = (early_reg[0] & early_reg[1]) | (early_reg[0] & rx_s_reg) |
                        (early_reg[1] & rx_s_reg);
`else
    assign sample_bit = rx_s_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg    <= 1'b1;
            rx_s_reg       <= 1'b1;
            rx_prev_reg    <= 1'b1;
            state_reg      <= S_IDLE;
            baud_count_reg <= 14'd0;
            bit_count_reg  <= 3'd0;
            shift_reg      <= 8'd0;
            two_stop_reg   <= 1'b0;
            odd_parity_reg <= 1'b0;
            parity_bad_reg <= 1'b0;
            stop1_bad_reg  <= 1'b0;
            frame_bad_reg  <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            rx_meta_reg <= rx_in;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
            done_reg    <= 1'b0;
            if (state_reg != S_IDLE) begin
                baud_count_reg <= decide ? RELOAD : baud_count_reg + 14'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (rx_prev_reg && !rx_s_reg) begin
                        baud_count_reg <= 14'd0;
                        state_reg      <= S_START;
                        two_stop_reg   <= two_stop;
                        odd_parity_reg <= odd_parity;
                    end
                end
                S_START: begin
                    if (decide) begin
                        if (sample_bit) begin
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg     <= S_DATA;
                            bit_count_reg <= 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shift_reg     <= {sample_bit, shift_reg[7:1]};
                        bit_count_reg <= bit_count_reg + 3'd1;
                        if (bit_count_reg == 3'd7) state_reg <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (decide) begin
                        parity_bad_reg <= ((^shift_reg) ^ sample_bit) != odd_parity_reg;
                        state_reg      <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (decide) begin
                        stop1_bad_reg <= ~sample_bit;
                        if (two_stop_reg) begin
                            state_reg <= S_STOP2;
                        end else begin
                            state_reg     <= S_IDLE;
                            done_reg      <= 1'b1;
                            frame_bad_reg <= ~sample_bit;
                        end
                    end
                end
                S_STOP2: begin
                    if (decide) begin
                        state_reg     <= S_IDLE;
                        done_reg      <= 1'b1;
                        frame_bad_reg <= stop1_bad_reg | ~sample_bit;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Completion beats a same-cycle acknowledge; only an unacknowledged held byte counts as overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_reg    <= 8'd0;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (done_reg) begin
            rx_data_reg    <= shift_reg;
            rx_valid_reg   <= 1'b1;
            parity_err_reg <= parity_bad_reg;
            frame_err_reg  <= frame_bad_reg;
            overrun_reg    <= rx_valid_reg & ~rx_ack;
        end else if (rx_ack && rx_valid_reg) begin
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign rx_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frame-level timing/result model plus literal spot checks.
module tb_uart_rx;

    localparam int D = 16;
    localparam int H = D / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       two_stop = 1'b0;
    logic       odd_parity = 1'b0;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    uart_rx #(.BAUD_DIVISOR(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .two_stop   (two_stop),
        .odd_parity (odd_parity),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int frame_no = 0;

    // Schedule of the frame in flight, in posedge numbers.
    int sch_bs = -1, sch_be = -1, sch_ve = -1;
    logic [7:0] sch_data = 8'd0;
    logic sch_perr = 1'b0, sch_ferr = 1'b0;
    int last_start = 0, last_rise = -1, lat_a = 0;

    logic [7:0] exp_data = 8'd0;
    logic exp_valid = 1'b0, exp_busy = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
    logic prev_valid = 1'b0;

    int ack_at_edge = -1;
    bit ack_rand_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Per-edge model and comparison.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (rst) begin
                exp_valid = 0; exp_busy = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0; exp_data = 0;
            end else begin
                exp_busy = (edge_n >= sch_bs) && (edge_n < sch_be);
                if (edge_n == sch_ve) begin
                    exp_ovr   = exp_valid && !rx_ack;
                    exp_valid = 1'b1;
                    exp_data  = sch_data;
                    exp_perr  = sch_perr;
                    exp_ferr  = sch_ferr;
                end else if (rx_ack && exp_valid) begin
                    exp_valid = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
                end
            end
            if (rx_valid === 1'b1 && prev_valid !== 1'b1) last_rise = edge_n;
            prev_valid = rx_valid;
            check("cycle{valid,busy,perr,ferr,ovr,data}",
                  {19'd0, rx_valid, rx_busy, parity_err, frame_err, overrun, (exp_valid ? rx_data : 8'h00)},
                  {19'd0, exp_valid, exp_busy, exp_perr, exp_ferr, exp_ovr, (exp_valid ? exp_data : 8'h00)});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            rx_ack = ack_rand_en ? ($urandom_range(0, 3) == 0) : (edge_n + 1 == ack_at_edge);
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic s1, input logic s2,
                              input logic two, input logic odd, input int idle,
                              input bit ack_done, input int abort_bit);
        logic [11:0] bits;
        int nb;
        int n;
        bits = {s2, s1, pb, d, 1'b0};
        nb = two ? 12 : 11;
        @(negedge clk);
        n = edge_n + 1;
        last_start = n;
        last_rise = -1;
        sch_data = d;
        sch_perr = ((^d) ^ pb) != odd;
        sch_ferr = !s1 || (two && !s2);
        sch_bs = n + 2;
        sch_be = n + H + 2 + (two ? 11 : 10) * D;
        sch_ve = sch_be + 1;
        if (ack_done) ack_at_edge = sch_ve;
        frame_no++;
        $display("frame %0d: data=%02h parity_bit=%0b stops=%0b%0b two_stop=%0b odd=%0b abort=%0d",
                 frame_no, d, pb, s1, s2, two, odd, abort_bit);
        for (int j = 0; j < nb; j++) begin
            rx_in = bits[j];
            if (j == 0) begin
                two_stop = two;
                odd_parity = odd;
            end
            if (j == 3) begin
                two_stop = 1'($urandom_range(0, 1));
                odd_parity = 1'($urandom_range(0, 1));
            end
            if (j == abort_bit) begin
                repeat (D / 2) @(negedge clk);
                rst = 1'b1;
                sch_bs = -1; sch_be = -1; sch_ve = -1;
                #1;
                check("rst_mid_valid", rx_valid, 0);
                check("rst_mid_data", rx_data, 0);
                check("rst_mid_flags", {parity_err, frame_err, overrun, rx_busy}, 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                rx_in = 1'b1;
                repeat (idle) @(negedge clk);
                return;
            end
            repeat (D) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack_at_edge = edge_n + 2;
        repeat (2) @(negedge clk);
        #1;
        check("ack_clears_valid", rx_valid, 0);
        check("ack_clears_flags", {parity_err, frame_err, overrun}, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic pb, s1, s2, two, odd;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_flags", {parity_err, frame_err, overrun, rx_busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5, even parity, one stop
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0, -1);
        lat_a = last_rise - last_start;
        check("a5_latency", lat_a, 171);
        check("a5_data", rx_data, 8'hA5);
        check("a5_status", {rx_valid, parity_err, frame_err, overrun}, 4'b1000);
        repeat (10) @(negedge clk);
        check("a5_held", rx_valid, 1);
        do_ack();

        // 0x03, odd parity expected, parity bit wrong
        send_frame(8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 0, -1);
        check("odd_data", rx_data, 8'h03);
        check("odd_perr", parity_err, 1);
        do_ack();

        // two stop bits: second one low, then both high
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0, -1);
        check("two_stop_ferr", {rx_valid, frame_err, rx_data}, {2'b11, 8'h5A});
        do_ack();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 0, -1);
        check("two_stop_ok", {rx_valid, frame_err}, 2'b10);
        check("two_stop_latency", last_rise - last_start, 187);
        check("two_stop_extra", (last_rise - last_start) - lat_a, 16);
        do_ack();

        // 5-cycle glitch in idle
        @(negedge clk);
        rx_in = 1'b0;
        sch_bs = edge_n + 3;
        sch_be = edge_n + 3 + H;
        sch_ve = -1;
        repeat (5) @(negedge clk);
        check("glitch_busy", rx_busy, 1);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("glitch_idle", {rx_valid, rx_busy}, 0);

        // back-to-back without ack, then with ack on the completion edge
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, -1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0, -1);
        check("overrun_set", {rx_valid, overrun, rx_data}, {2'b11, 8'h22});
        do_ack();
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, -1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1, -1);
        check("ack_at_completion", {rx_valid, overrun, rx_data}, {2'b10, 8'h22});

        // reset in the middle of DATA while a byte is held, then a clean frame
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6, 0, 4);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0, -1);
        check("after_rst_frame", {rx_valid, parity_err, frame_err, overrun, rx_data}, {4'b1000, 8'h3C});
        do_ack();

        // randomized frames with random acknowledges
        ack_rand_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            d   = 8'($urandom_range(0, 255));
            two = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            pb  = (^d) ^ odd ^ ($urandom_range(0, 5) == 0);
            s1  = ($urandom_range(0, 6) != 0);
            s2  = ($urandom_range(0, 6) != 0);
            send_frame(d, pb, s1, s2, two, odd, $urandom_range(2, 20), 0, -1);
        end
        ack_rand_en = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
